// File: rtl/eos_mq.sv
// ---------------------------------------------------------------------------
// eos_mq -- egress scheduler with NQ strict-priority metadata queues.
//
// Each queue is a DEPTH-entry FIFO of MD_W-bit descriptors. A queue may be
// served when it holds data and its time-slot gate is open. Queue RL_Q must
// also have enough token-bucket credit. A three-state FSM (IDLE/ISSUE/WAIT)
// pops the lowest-index eligible queue, presents the descriptor with a
// one-cycle strobe, and then waits for the downstream "packet done" pulse.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_md/in_qid      descriptor and target queue, written when in_md_wr=1
//   in_gate_mask      per-queue gate-open bits
//   in_rl_inc/cost    credit added per cycle / consumed per RL_Q dequeue
//   in_rl_max         credit saturation ceiling
//   in_out_ready      downstream can take a descriptor
//   in_pkt_done       last issued packet has left (only honoured in WAIT)
//   out_md/out_md_wr  issued descriptor and its one-cycle strobe
//   out_used_cnt      packed occupancy, queue i at [i*CW +: CW]
//   out_in_cnt        accepted writes
//   out_out_cnt       issued descriptors
//   out_drop_cnt      dropped writes
// ---------------------------------------------------------------------------
module eos_mq #(
    parameter int NQ    = 4,
    parameter int MD_W  = 8,
    parameter int DEPTH = 16,
    parameter int RL_Q  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [MD_W-1:0]                      in_md,
    input  logic [$clog2(NQ)-1:0]                in_qid,
    input  logic                                 in_md_wr,
    input  logic [NQ-1:0]                        in_gate_mask,
    input  logic [15:0]                          in_rl_inc,
    input  logic [15:0]                          in_rl_cost,
    input  logic [31:0]                          in_rl_max,
    input  logic                                 in_out_ready,
    input  logic                                 in_pkt_done,
    output logic [MD_W-1:0]                      out_md,
    output logic                                 out_md_wr,
    output logic [NQ*($clog2(DEPTH)+1)-1:0]      out_used_cnt,
    output logic [63:0]                          out_in_cnt,
    output logic [63:0]                          out_out_cnt,
    output logic [63:0]                          out_drop_cnt
);

    localparam int QW = $clog2(NQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;

    logic [MD_W-1:0]     mem_q    [NQ][DEPTH];
    logic [PW-1:0]       wr_ptr_q [NQ];
    logic [PW-1:0]       rd_ptr_q [NQ];
    logic [CW-1:0]       cnt_q    [NQ];

    logic [31:0]         credit_q, credit_d;
    logic [MD_W-1:0]     md_q;
    logic [63:0]         in_cnt_q, out_cnt_q, drop_cnt_q;

    logic [NQ-1:0]       elig;
    logic                any_elig;
    logic [QW-1:0]       sel;
    logic                pop_en;
    logic [NQ-1:0]       pop_vec;
    logic [NQ-1:0]       wr_vec;
    logic                qid_ok;
    logic                wr_acc;
    logic                wr_drop;

    // -----------------------------------------------------------------------
    // Eligibility and strict-priority selection (lowest index wins)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        elig     = '0;
        any_elig = 1'b0;
        sel      = '0;
        for (int i = 0; i < NQ; i++) begin
            elig[i] = (cnt_q[i] != '0) && in_gate_mask[i] &&
                      ((i != RL_Q) || (credit_q >= {16'b0, in_rl_cost}));
        end
        // Scan downward so the last hit is the lowest eligible index.
        for (int i = NQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel      = QW'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        for (int i = 0; i < NQ; i++) begin
            pop_vec[i] = pop_en && (sel == QW'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Write acceptance: a full queue still accepts when it is popped in the
    // same cycle, since a slot frees up at the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        qid_ok = int'(in_qid) < NQ;
        wr_vec = '0;
        for (int i = 0; i < NQ; i++) begin
            wr_vec[i] = in_md_wr && qid_ok && (in_qid == QW'(i)) &&
                        ((cnt_q[i] != CW'(DEPTH)) || pop_vec[i]);
        end
        wr_acc  = |wr_vec;
        wr_drop = in_md_wr && !wr_acc;
    end

    // -----------------------------------------------------------------------
    // Token bucket: add, saturate at the ceiling, then subtract the cost of a
    // dequeue from RL_Q, clamping at zero.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [32:0] sum;
        logic [31:0] sat;
        sum = {1'b0, credit_q} + {17'b0, in_rl_inc};
        sat = (sum > {1'b0, in_rl_max}) ? in_rl_max : sum[31:0];
        credit_d = sat;
        if (pop_vec[RL_Q]) begin
            credit_d = (sat >= {16'b0, in_rl_cost}) ? (sat - {16'b0, in_rl_cost}) : '0;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_out_ready && any_elig) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (in_pkt_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop_en    = (state_q == S_IDLE) && in_out_ready && any_elig;
        out_md_wr = (state_q == S_ISSUE);
    end

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; clearing pointers and
    // counts empties every queue, and stale entries are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (wr_vec[i]) mem_q[i][wr_ptr_q[i]] <= in_md;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NQ; i++) begin
                if (wr_vec[i])  wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                if (pop_vec[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                cnt_q[i] <= cnt_q[i] + CW'(wr_vec[i]) - CW'(pop_vec[i]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issue register, credit and statistics
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q       <= '0;
            credit_q   <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            // The read sees the pre-edge entry even if the same slot is
            // rewritten at this edge (full queue, simultaneous write).
            if (pop_en) md_q <= mem_q[sel][rd_ptr_q[sel]];
            credit_q   <= credit_d;
            in_cnt_q   <= in_cnt_q   + 64'(wr_acc);
            out_cnt_q  <= out_cnt_q  + 64'(out_md_wr);
            drop_cnt_q <= drop_cnt_q + 64'(wr_drop);
        end
    end

    always_comb begin
        out_used_cnt = '0;
        for (int i = 0; i < NQ; i++) begin
            out_used_cnt[i*CW +: CW] = cnt_q[i];
        end
    end

    assign out_md       = md_q;
    assign out_in_cnt   = in_cnt_q;
    assign out_out_cnt  = out_cnt_q;
    assign out_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eos_mq.sv
// ---------------------------------------------------------------------------
// tb_eos_mq -- directed self-checking bench for eos_mq (default parameters).
// Inputs are driven and outputs sampled on the falling edge; every issued
// descriptor is recorded with the rising-edge count at which it appeared.
// ---------------------------------------------------------------------------
module tb_eos_mq;

    localparam int NQ    = 4;
    localparam int MD_W  = 8;
    localparam int DEPTH = 16;
    localparam int RL_Q  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [MD_W-1:0]       in_md;
    logic [1:0]            in_qid;
    logic                  in_md_wr;
    logic [NQ-1:0]         in_gate_mask;
    logic [15:0]           in_rl_inc;
    logic [15:0]           in_rl_cost;
    logic [31:0]           in_rl_max;
    logic                  in_out_ready;
    logic                  in_pkt_done;
    logic [MD_W-1:0]       out_md;
    logic                  out_md_wr;
    logic [NQ*CW-1:0]      out_used_cnt;
    logic [63:0]           out_in_cnt;
    logic [63:0]           out_out_cnt;
    logic [63:0]           out_drop_cnt;

    eos_mq #(.NQ(NQ), .MD_W(MD_W), .DEPTH(DEPTH), .RL_Q(RL_Q)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_md        (in_md),
        .in_qid       (in_qid),
        .in_md_wr     (in_md_wr),
        .in_gate_mask (in_gate_mask),
        .in_rl_inc    (in_rl_inc),
        .in_rl_cost   (in_rl_cost),
        .in_rl_max    (in_rl_max),
        .in_out_ready (in_out_ready),
        .in_pkt_done  (in_pkt_done),
        .out_md       (out_md),
        .out_md_wr    (out_md_wr),
        .out_used_cnt (out_used_cnt),
        .out_in_cnt   (out_in_cnt),
        .out_out_cnt  (out_out_cnt),
        .out_drop_cnt (out_drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [MD_W-1:0] got_md [$];
    int              got_cyc[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] used_of(input int q);
        return 64'(out_used_cnt[q*CW +: CW]);
    endfunction

    // One clock: wait for the falling edge, then log any issue strobe.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (out_md_wr) begin
                got_md.push_back(out_md);
                got_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_md_wr = 1'b0;
        step(2);
        rst_n = 1'b1;
        cyc   = 0;
        got_md.delete();
        got_cyc.delete();
    endtask

    task automatic wr(input int q, input int d);
        in_qid   = 2'(q);
        in_md    = MD_W'(d);
        in_md_wr = 1'b1;
        step();
        in_md_wr = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget, input string tag);
        int b = 0;
        while (got_md.size() < n && b < budget) begin
            step();
            b++;
        end
        check(tag, 64'(got_md.size()), 64'(n));
    endtask

    initial begin
        rst_n        = 1'b0;
        in_md        = '0;
        in_qid       = '0;
        in_md_wr     = 1'b0;
        in_gate_mask = '0;
        in_rl_inc    = '0;
        in_rl_cost   = '0;
        in_rl_max    = '0;
        in_out_ready = 1'b0;
        in_pkt_done  = 1'b0;

        // ---- Reset state ------------------------------------------------
        step(2);
        check("rst_md",   64'(out_md),    64'd0);
        check("rst_wr",   64'(out_md_wr), 64'd0);
        check("rst_used", 64'(out_used_cnt), 64'd0);
        check("rst_in",   out_in_cnt,   64'd0);
        check("rst_out",  out_out_cnt,  64'd0);
        check("rst_drop", out_drop_cnt, 64'd0);

        // ---- Priority: q1 beats q3, second issue waits for pkt_done -------
        apply_reset();
        in_gate_mask = 4'hF;
        wr(3, 8'h11);
        wr(1, 8'h22);
        check("prio_used3", used_of(3), 64'd1);
        check("prio_used1", used_of(1), 64'd1);
        in_out_ready = 1'b1;
        wait_issues(1, 10, "prio_n1");
        if (got_md.size() > 0) check("prio_first", 64'(got_md[0]), 64'h22);
        step(8);
        check("prio_hold", 64'(got_md.size()), 64'd1);
        in_pkt_done = 1'b1;
        step();
        in_pkt_done = 1'b0;
        wait_issues(2, 10, "prio_n2");
        if (got_md.size() > 1) check("prio_second", 64'(got_md[1]), 64'h11);
        step(2);
        check("prio_incnt",  out_in_cnt,  64'd2);
        check("prio_outcnt", out_out_cnt, 64'd2);

        // ---- Overflow on q0, then FIFO-order drain -----------------------
        apply_reset();
        in_gate_mask = 4'h0;
        in_out_ready = 1'b1;
        in_pkt_done  = 1'b1;
        for (int i = 0; i < 17; i++) wr(0, 8'h40 + i);
        check("ovf_used", used_of(0), 64'd16);
        check("ovf_drop", out_drop_cnt, 64'd1);
        check("ovf_in",   out_in_cnt,   64'd16);
        in_gate_mask = 4'h1;
        wait_issues(16, 100, "ovf_n");
        for (int k = 0; k < 16 && k < got_md.size(); k++)
            check($sformatf("ovf_md%0d", k), 64'(got_md[k]), 64'h40 + 64'(k));
        for (int k = 1; k < got_cyc.size(); k++)
            check($sformatf("ovf_gap%0d", k), 64'(got_cyc[k] - got_cyc[k-1] >= 3), 64'd1);
        check("ovf_empty", used_of(0), 64'd0);

        // ---- Rate-limited q2: inc=1 cost=10 max=100 ----------------------
        in_rl_inc  = 16'd1;
        in_rl_cost = 16'd10;
        in_rl_max  = 32'd100;
        apply_reset();
        in_gate_mask = 4'hF;
        in_out_ready = 1'b1;
        in_pkt_done  = 1'b1;
        wr(2, 8'hA0);
        wr(2, 8'hA1);
        wr(2, 8'hA2);
        wait_issues(3, 80, "rl_n");
        if (got_cyc.size() > 0) check("rl_first", 64'(got_cyc[0] >= 10), 64'd1);
        for (int k = 1; k < got_cyc.size(); k++)
            check($sformatf("rl_gap%0d", k), 64'(got_cyc[k] - got_cyc[k-1] >= 10), 64'd1);
        if (got_md.size() > 2) check("rl_last", 64'(got_md[2]), 64'hA2);
        in_rl_inc  = '0;
        in_rl_cost = '0;
        in_rl_max  = '0;

        // ---- Back-pressure: no issue while ready=0 -----------------------
        apply_reset();
        in_gate_mask = 4'hF;
        in_out_ready = 1'b0;
        in_pkt_done  = 1'b1;
        wr(0, 8'h5A);
        step(20);
        check("bp_none", 64'(got_md.size()), 64'd0);
        check("bp_wr0",  64'(out_md_wr), 64'd0);
        in_out_ready = 1'b1;
        // Strobe is up after the first rising edge, so the second rising
        // edge after ready rose captures it; it lasts one cycle only.
        step();
        check("bp_wr1",  64'(out_md_wr), 64'd1);
        check("bp_md",   64'(out_md), 64'h5A);
        step();
        check("bp_wr2",  64'(out_md_wr), 64'd0);

        // ---- Reset during WAIT with 5 entries queued ---------------------
        apply_reset();
        in_gate_mask = 4'h0;
        in_out_ready = 1'b1;
        in_pkt_done  = 1'b0;
        for (int i = 0; i < 6; i++) wr(0, 8'h60 + i);
        in_gate_mask = 4'h1;
        wait_issues(1, 10, "rw_n1");
        step(2);
        check("rw_used5", used_of(0), 64'd5);
        rst_n = 1'b0;
        #1;
        check("rw_md",   64'(out_md),    64'd0);
        check("rw_wr",   64'(out_md_wr), 64'd0);
        check("rw_used", 64'(out_used_cnt), 64'd0);
        check("rw_in",   out_in_cnt,   64'd0);
        check("rw_out",  out_out_cnt,  64'd0);
        check("rw_drop", out_drop_cnt, 64'd0);
        step();
        rst_n = 1'b1;
        cyc   = 0;
        got_md.delete();
        got_cyc.delete();
        in_gate_mask = 4'hF;
        in_pkt_done  = 1'b1;
        step(10);
        check("rw_quiet", 64'(got_md.size()), 64'd0);
        wr(0, 8'h77);
        wait_issues(1, 10, "rw_fresh_n");
        if (got_md.size() > 0) check("rw_fresh", 64'(got_md[0]), 64'h77);

        // ---- Write to full q1 in the cycle it pops -----------------------
        apply_reset();
        in_gate_mask = 4'h0;
        in_out_ready = 1'b1;
        in_pkt_done  = 1'b1;
        for (int i = 0; i < 16; i++) wr(1, 8'h80 + i);
        check("fp_full", used_of(1), 64'd16);
        in_gate_mask = 4'h2;
        wr(1, 8'h99);
        check("fp_popped", 64'(got_md.size()), 64'd1);
        check("fp_used",   used_of(1), 64'd16);
        check("fp_drop",   out_drop_cnt, 64'd0);
        check("fp_in",     out_in_cnt,   64'd17);
        wait_issues(17, 80, "fp_n");
        if (got_md.size() > 16) begin
            check("fp_first", 64'(got_md[0]),  64'h80);
            check("fp_p15",   64'(got_md[15]), 64'h8F);
            check("fp_last",  64'(got_md[16]), 64'h99);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
